// File: rtl/bus_result_monitor.sv
// Passive 6502 bus snooper: watches writes to one address and reports a PASS/FAIL verdict.
// Optional write history storage is enabled with `define MON_HISTORY_EN.
`timescale 1ns/1ps
module bus_result_monitor #(
  parameter logic [15:0] WATCH_ADDR     = 16'h0071,
  parameter logic [7:0]  EXPECT         = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 140
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic        arm,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic [7:0]  last_val,
  output logic [7:0]  wr_count,
  output logic [15:0] cycles,
  output logic [31:0] hist
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t        state, state_nx;
  logic          done_nx, pass_nx;
  logic [7:0]    last_nx, cnt_nx;
  logic [CW-1:0] cyc_nx;
  logic          watch_wr;
  logic [31:0]   hist_nx;

  assign watch_wr = memwrite && (address == WATCH_ADDR);

  // Next-state and next-output decode
  always_comb begin
    state_nx = state;
    done_nx  = done;
    pass_nx  = pass;
    last_nx  = last_val;
    cnt_nx   = wr_count;
    cyc_nx   = cycles;
    hist_nx  = hist;
    if (arm) begin
      // Arm always (re)starts a clean run; a same-edge watch write is dropped.
      state_nx = S_RUN;
      done_nx  = 1'b0;
      pass_nx  = 1'b0;
      last_nx  = 8'h00;
      cnt_nx   = 8'h00;
      cyc_nx   = '0;
      hist_nx  = 32'h0;
    end else if (state == S_RUN) begin
      if (cycles != {CW{1'b1}}) cyc_nx = cycles + CW'(1);
      if (watch_wr) begin
        last_nx = data;
        if (wr_count != 8'hFF) cnt_nx = wr_count + 8'd1;
        hist_nx = {hist[23:0], data};
      end
      if (watch_wr && (data == EXPECT)) begin
        state_nx = S_PASS;
        done_nx  = 1'b1;
        pass_nx  = 1'b1;
      end else if (cycles == TIMEOUT_LAST) begin
        state_nx = S_FAIL;
        done_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      pass     <= 1'b0;
      last_val <= 8'h00;
      wr_count <= 8'h00;
      cycles   <= '0;
    end else begin
      state    <= state_nx;
      done     <= done_nx;
      pass     <= pass_nx;
      last_val <= last_nx;
      wr_count <= cnt_nx;
      cycles   <= cyc_nx;
    end
  end

`ifdef MON_HISTORY_EN
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) hist <= 32'h0;
    else       hist <= hist_nx;
  end
`else
  assign hist = 32'h0;
`endif

endmodule

// File: tb/tb_bus_result_monitor.sv
// Scoreboard bench for bus_result_monitor: verdicts are queued by stimulus and
// checked by a monitor on every rising edge of done; plus direct state snapshots.
`timescale 1ns/1ps
module tb_bus_result_monitor;

  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data = 8'h00;
  logic        memwrite = 1'b0;
  logic        done, pass;
  logic [7:0]  last_val, wr_count;
  logic [15:0] cycles;
  logic [31:0] hist;

  typedef struct {
    string       name;
    logic        done;
    logic        pass;
    logic [7:0]  last_val;
    logic [7:0]  wr_count;
    logic [15:0] cycles;
    logic [31:0] hist;
  } exp_t;

  exp_t verdict_q[$];
  int   checks = 0;
  int   failures = 0;
  logic done_prev = 1'b0;

  bus_result_monitor dut (
    .ph2(ph2), .reset(reset), .arm(arm), .address(address), .data(data),
    .memwrite(memwrite), .done(done), .pass(pass), .last_val(last_val),
    .wr_count(wr_count), .cycles(cycles), .hist(hist)
  );

  always #10 ph2 = ~ph2;

  function automatic logic [31:0] hx(input logic [31:0] v);
`ifdef MON_HISTORY_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  function automatic exp_t mk(input string n, input logic d, input logic p, input logic [7:0] lv,
                              input logic [7:0] wc, input logic [15:0] cy, input logic [31:0] h);
    exp_t e;
    e.name = n; e.done = d; e.pass = p; e.last_val = lv;
    e.wr_count = wc; e.cycles = cy; e.hist = hx(h);
    return e;
  endfunction

  task automatic compare(input exp_t e);
    checks++;
    if ({done, pass, last_val, wr_count, cycles, hist} !==
        {e.done, e.pass, e.last_val, e.wr_count, e.cycles, e.hist}) begin
      failures++;
      $display("FAIL %s: got done=%b pass=%b last=%h cnt=%h cyc=%0d hist=%h; want done=%b pass=%b last=%h cnt=%h cyc=%0d hist=%h",
               e.name, done, pass, last_val, wr_count, cycles, hist,
               e.done, e.pass, e.last_val, e.wr_count, e.cycles, e.hist);
    end
  endtask

  // Monitor: each new verdict must match the oldest queued expectation
  always @(negedge ph2) begin
    if (done && !done_prev) begin
      if (verdict_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_verdict: got pass=%b cyc=%0d; want no verdict", pass, cycles);
      end else begin
        compare(verdict_q.pop_front());
      end
    end
    done_prev <= done;
  end

  task automatic tick();
    @(posedge ph2);
    #2;
  endtask

  task automatic idle(input int n);
    memwrite = 1'b0;
    repeat (n) tick();
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic we);
    address = a; data = d; memwrite = we;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish; want finish");
    $fatal(1);
  end

  initial begin
    tick();
    compare(mk("reset_state", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));
    tick();
    reset = 1'b0;
    idle(3);
    compare(mk("idle_no_arm", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));

    // 1: single FF write after 9 idle run cycles
    arm_pulse();
    compare(mk("t1_armed", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));
    idle(9);
    compare(mk("t1_running", 0, 0, 8'h00, 8'h00, 16'd9, 32'h0));
    verdict_q.push_back(mk("t1_pass", 1, 1, 8'hFF, 8'h01, 16'd10, 32'h000000FF));
    bus(16'h0071, 8'hFF, 1'b1);
    idle(2);
    compare(mk("t1_hold", 1, 1, 8'hFF, 8'h01, 16'd10, 32'h000000FF));

    // 2: incrementing intermediate results, one write to a neighbour address
    arm_pulse();
    bus(16'h0071, 8'h00, 1'b1);
    bus(16'h0070, 8'hFF, 1'b1);
    bus(16'h0071, 8'h01, 1'b1);
    bus(16'h0071, 8'h02, 1'b1);
    compare(mk("t2_mid", 0, 0, 8'h02, 8'h03, 16'd4, 32'h00000102));
    verdict_q.push_back(mk("t2_pass", 1, 1, 8'hFF, 8'h04, 16'd5, 32'h000102FF));
    bus(16'h0071, 8'hFF, 1'b1);

    // 3: wrong value, mirror address, read of watch address -> timeout
    arm_pulse();
    bus(16'h0071, 8'h7F, 1'b1);
    bus(16'h1071, 8'hFF, 1'b1);
    bus(16'h0071, 8'hFF, 1'b0);
    bus(16'h0070, 8'hFF, 1'b1);
    idle(135);
    compare(mk("t3_pre_timeout", 0, 0, 8'h7F, 8'h01, 16'd139, 32'h0000007F));
    verdict_q.push_back(mk("t3_fail", 1, 0, 8'h7F, 8'h01, 16'd140, 32'h0000007F));
    idle(1);
    idle(3);
    compare(mk("t3_hold", 1, 0, 8'h7F, 8'h01, 16'd140, 32'h0000007F));

    // 6: re-arm from FAIL, then pass
    arm_pulse();
    compare(mk("t6_rearm", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));
    verdict_q.push_back(mk("t6_pass", 1, 1, 8'hFF, 8'h01, 16'd1, 32'h000000FF));
    bus(16'h0071, 8'hFF, 1'b1);

    // 4: matching write on the timeout edge
    arm_pulse();
    idle(139);
    compare(mk("t4_pre_timeout", 0, 0, 8'h00, 8'h00, 16'd139, 32'h0));
    verdict_q.push_back(mk("t4_pass_on_timeout", 1, 1, 8'hFF, 8'h01, 16'd140, 32'h000000FF));
    bus(16'h0071, 8'hFF, 1'b1);

    // 5: asynchronous reset mid-run
    arm_pulse();
    bus(16'h0071, 8'h7F, 1'b1);
    idle(49);
    compare(mk("t5_before_reset", 0, 0, 8'h7F, 8'h01, 16'd50, 32'h0000007F));
    #3 reset = 1'b1;
    #1 compare(mk("t5_async_reset", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));
    tick();
    tick();
    reset = 1'b0;
    idle(200);
    compare(mk("t5_no_verdict", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));

    // arm during RUN restarts and discards the same-edge watch write
    arm_pulse();
    bus(16'h0071, 8'h33, 1'b1);
    compare(mk("rs_first", 0, 0, 8'h33, 8'h01, 16'd1, 32'h00000033));
    arm = 1'b1;
    bus(16'h0071, 8'hFF, 1'b1);
    arm = 1'b0;
    compare(mk("rs_restart", 0, 0, 8'h00, 8'h00, 16'd0, 32'h0));
    verdict_q.push_back(mk("rs_pass", 1, 1, 8'hFF, 8'h02, 16'd2, 32'h000055FF));
    bus(16'h0071, 8'h55, 1'b1);
    bus(16'h0071, 8'hFF, 1'b1);

    idle(3);
    checks++;
    if (verdict_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending verdicts; want 0", verdict_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
